// File: rtl/smooth_row_collector.sv
// Ping-pong row buffer behind the smoothing filter: skips fill samples, captures one row per bank, drains in fill order.
// Optional row_max output enabled by defining SMOOTH_ROW_MAX_EN.
module smooth_row_collector #(
  parameter int ROW_LEN  = 150,
  parameter int SKIP_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       row_start,
  input  logic [7:0] pix_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] row_cnt,
`ifdef SMOOTH_ROW_MAX_EN
  output logic [7:0] row_max,
`endif
  output logic       overflow
);

  localparam int AW = $clog2(2 * ROW_LEN);
  localparam logic [7:0] COL_LAST = 8'(ROW_LEN - 1);
  localparam logic [3:0] SKIP_LAST = 4'(SKIP_LEN - 1);
  localparam logic [AW-1:0] BANK1 = AW'(ROW_LEN);

  typedef enum logic [1:0] {IDLE, SKIP, FILL} state_t;

  state_t      state;
  logic [3:0]  skip_cnt;
  logic [7:0]  col;
  logic        wbank;
  logic [1:0]  full;

  logic        rbank;
  logic        obank;
  logic [7:0]  rcol;

  logic [7:0]  mem [2*ROW_LEN];

  logic          start;
  logic          fill_wr;
  logic          begin0;
  logic          wr_en;
  logic [7:0]    wr_col;
  logic          row_done;
  logic          xfer;
  logic          load;
  logic [1:0]    set_full;
  logic [1:0]    free;
  logic [1:0]    full_eff;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Write-side decode and bank bookkeeping signals.
  always_comb begin
    start    = enb & row_start;
    xfer     = out_valid & out_ready;
    free     = 2'b00;
    free[obank] = xfer & out_last;
    full_eff = full & ~free;
    begin0   = start & ~full_eff[wbank] & (SKIP_LEN == 0);
    fill_wr  = enb & ~row_start & (state == FILL);
    wr_en    = begin0 | fill_wr;
    wr_col   = begin0 ? 8'd0 : col;
    row_done = fill_wr & (col == COL_LAST);
    set_full = 2'b00;
    set_full[wbank] = row_done;
    wr_addr  = (wbank ? BANK1 : '0) + AW'(wr_col);
    rd_addr  = (rbank ? BANK1 : '0) + AW'(rcol);
    load     = (~out_valid | out_ready) & full[rbank];
  end

  // Write FSM: row start, skip of pipeline-fill samples, column fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
      col      <= '0;
      wbank    <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      if (full_eff[wbank]) begin
        overflow <= 1'b1;
        state    <= IDLE;
      end else if (SKIP_LEN == 0) begin
        state <= FILL;
        col   <= 8'd1;
      end else if (SKIP_LEN == 1) begin
        state <= FILL;
        col   <= 8'd0;
      end else begin
        state    <= SKIP;
        skip_cnt <= 4'd1;
      end
    end else if (enb) begin
      unique case (state)
        SKIP: begin
          if (skip_cnt == SKIP_LAST) begin
            state <= FILL;
            col   <= 8'd0;
          end else begin
            skip_cnt <= skip_cnt + 4'd1;
          end
        end
        FILL: begin
          if (row_done) begin
            state <= IDLE;
            wbank <= ~wbank;
          end else begin
            col <= col + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bank full flags: set by the writer, cleared on the last transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) full <= 2'b00;
    else        full <= (full & ~free) | set_full;
  end

  // Row storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pix_in;
  end

  // Read side: registered output stage refilled on every transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      rbank     <= 1'b0;
      obank     <= 1'b0;
      rcol      <= '0;
      row_cnt   <= '0;
    end else begin
      if (xfer && out_last) row_cnt <= row_cnt + 8'd1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_addr];
        out_last  <= (rcol == COL_LAST);
        obank     <= rbank;
        if (rcol == COL_LAST) begin
          rcol  <= '0;
          rbank <= ~rbank;
        end else begin
          rcol <= rcol + 8'd1;
        end
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SMOOTH_ROW_MAX_EN
  logic [1:0][7:0] bmax;

  // Running maximum per bank, restarted at column 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bmax <= '0;
    end else if (wr_en) begin
      if (wr_col == 8'd0 || pix_in > bmax[wbank])
        bmax[wbank] <= pix_in;
    end
  end

  // Latch the bank maximum when its first pixel is loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) row_max <= '0;
    else if (load && rcol == 8'd0) row_max <= bmax[rbank];
  end
`endif

endmodule

// File: tb/tb_smooth_row_collector.sv
// Scoreboard bench for smooth_row_collector.
// Stimulus pushes expected pixels; a negedge monitor pops on transfers.
module tb_smooth_row_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enb = 1'b0;
  logic       row_start = 1'b0;
  logic [7:0] pix_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] row_cnt;
  logic       overflow;
`ifdef SMOOTH_ROW_MAX_EN
  logic [7:0] row_max;
  bit         max_chk = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_n = 0;
  int mark_n = -1;
  int mark_cyc = 0;
  int last_cyc = 0;
  int ready_mode = 2;
  logic [8:0] q[$];

  smooth_row_collector dut (
    .clk(clk),
    .reset(reset),
    .enb(enb),
    .row_start(row_start),
    .pix_in(pix_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .row_cnt(row_cnt),
`ifdef SMOOTH_ROW_MAX_EN
    .row_max(row_max),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // out_ready pattern generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor: transfers against scoreboard, stability while stalled
  initial begin
    bit         held = 1'b0;
    logic [8:0] hv = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_hold", int'({out_last, out_data}), int'(hv));
        end
`ifdef SMOOTH_ROW_MAX_EN
        if (max_chk && out_valid) chk("row_max", int'(row_max), 8'hC8);
`endif
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got %0d expected none", out_data);
          end else begin
            e = q.pop_front();
            chk("xfer", int'({out_last, out_data}), int'(e));
          end
          if (xfer_n == mark_n) mark_cyc = cyc;
          last_cyc = cyc;
          xfer_n++;
          held = 1'b0;
        end else if (out_valid) begin
          held = 1'b1;
          hv = {out_last, out_data};
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    enb = 1'b0;
    row_start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_row_cnt", int'(row_cnt), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b1;
  endtask

  // n samples, pixel i = i*mul+add, row_start on the first
  task automatic send_row(input int n, input int mul, input int add,
                          input bit expect_out, input int hot);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      p = 8'((i * mul + add) & 255);
      if (i == hot) p = 8'hC8;
      enb = 1'b1;
      row_start = (i == 0);
      pix_in = p;
      if (expect_out && i >= 4) q.push_back({(i == 153), p});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      enb = 1'b0;
      row_start = 1'b0;
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
      q.delete();
    end
    idle(3);
  endtask

  initial begin
    int base;
    do_reset();

    // single row, ready high
    ready_mode = 0;
    send_row(154, 1, 0, 1'b1, -1);
    idle(1);
    wait_empty("row1", 400);
    chk("row1_cnt", int'(row_cnt), 1);
    chk("row1_idle", int'(out_valid), 0);

    // same row, ready toggling
    ready_mode = 1;
    send_row(154, 1, 0, 1'b1, -1);
    idle(1);
    wait_empty("toggle", 700);
    chk("toggle_cnt", int'(row_cnt), 2);

    // three rows with ready low: third dropped
    do_reset();
    ready_mode = 2;
    send_row(154, 1, 10, 1'b1, -1);
    send_row(154, 2, 1, 1'b1, -1);
    send_row(154, 5, 7, 1'b0, -1);
    idle(4);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_no_drain", int'(row_cnt), 0);
    mark_n = xfer_n;
    ready_mode = 0;
    wait_empty("ovf", 800);
    chk("ovf_cnt", int'(row_cnt), 2);
    chk("ovf_sticky", int'(overflow), 1);
    chk("b2b_cycles", last_cyc - mark_cyc, 299);

    // row restart at fill column 70
    do_reset();
    ready_mode = 0;
    send_row(74, 1, 200, 1'b0, -1);
    send_row(154, 3, 0, 1'b1, -1);
    idle(1);
    wait_empty("restart", 400);
    chk("restart_cnt", int'(row_cnt), 1);

    // reset pulse mid-drain
    base = xfer_n;
    send_row(154, 1, 0, 1'b1, -1);
    idle(1);
    for (int k = 0; k < 400 && xfer_n < base + 20; k++) @(negedge clk);
    chk("pulse_reached", int'(xfer_n >= base + 20), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("pulse_valid", int'(out_valid), 0);
    chk("pulse_cnt", int'(row_cnt), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    send_row(154, 7, 3, 1'b1, -1);
    idle(1);
    wait_empty("post_pulse", 400);
    chk("post_pulse_cnt", int'(row_cnt), 1);

`ifdef SMOOTH_ROW_MAX_EN
    do_reset();
    send_row(154, 1, 0, 1'b0, -1);
    idle(1);
    q.delete();
    idle(170);
    for (int i = 4; i < 154; i++)
      q.push_back({(i == 153), (i == 90) ? 8'hC8 : 8'(i & 63)});
    max_chk = 1'b1;
    idle(1);
    begin
      @(posedge clk);
    end
    max_chk = 1'b0;
    do_reset();
    max_chk = 1'b1;
    for (int i = 0; i < 154; i++) begin
      @(posedge clk);
      #1;
      enb = 1'b1;
      row_start = (i == 0);
      pix_in = (i == 90) ? 8'hC8 : 8'(i & 63);
    end
    idle(1);
    wait_empty("rowmax", 400);
    max_chk = 1'b0;
    chk("rowmax_cnt", int'(row_cnt), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
